avalon_sample_reader: RTL and testbench
=======================================

Name: avalon_sample_reader

Overview:
- Avalon-MM read master that fetches a block of 32-bit audio sample words from the on-chip memory slave and presents them as a valid/ready stream to the audio output path.
- Sits between the on-chip sample memory (fixed-latency, no waitrequest) and the jukebox playback logic.
- The CPU or sequencer programs the base word address and length, then pulses start.
- Reads are pipelined, with credit-based flow control against an internal FIFO.

Parameters:
- ADDR_W, 16, word-address width of the memory slave.
- DATA_W, 32, data width of the slave and of the stream.
- LEN_W, 16, width of the transfer-length field in words.
- READ_LATENCY, 1, cycles from read issue (avm_read high at a clock edge) to valid avm_readdata. Legal values 1..3.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least READ_LATENCY+1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr/length. Ignored while busy.
- abort  in  1  one-cycle pulse; cancels the current transfer.
- base_addr  in  ADDR_W  first word address.
- length  in  LEN_W  number of words to read.
- busy  out  1  high from the cycle after an accepted start until the cycle done or aborted pulses.
- done  out  1  one-cycle pulse when the last word is accepted on the stream.
- aborted  out  1  one-cycle pulse when abort completes.
- avm_address  out  ADDR_W  word address to the slave.
- avm_chipselect  out  1  asserted together with avm_read.
- avm_read  out  1  read request; accepted every cycle it is high.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_readdata  in  DATA_W  slave read data.
- src_data  out  DATA_W  stream data (FIFO head).
- src_valid  out  1  stream data valid.
- src_ready  in  1  downstream ready.

Behaviour:
- Reset values: busy, done, aborted, avm_read, avm_chipselect, src_valid = 0. avm_address = 0. FIFO empty. State IDLE.
- FSM states:
  - IDLE. On start with length != 0: latch base_addr into addr_reg and length into remaining, then go to ISSUE. On start with length == 0: pulse done on the next cycle and stay in IDLE; busy never rises.
  - ISSUE. Drive avm_read = avm_chipselect = 1 and avm_address = addr_reg in any cycle where credit is available, i.e. fifo_count + inflight < FIFO_DEPTH. Each issue increments addr_reg modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and decrements remaining. When the final read issues, go to DRAIN.
  - DRAIN. Wait until inflight == 0 and the FIFO is empty with the final word accepted, then pulse done, deassert busy and return to IDLE.
  - FLUSH (entered on abort from ISSUE or DRAIN). Stop issuing immediately in the same cycle abort is sampled. Discard returning in-flight data. Clear the FIFO. When inflight == 0, pulse aborted and return to IDLE. abort in IDLE is ignored.
- Read return tracking:
  - A READ_LATENCY-deep valid shift register tags each issued read.
  - When a tag exits and the state is not FLUSH, write avm_readdata into the FIFO.
  - inflight equals the population count of this shift register.
- Credit rule guarantees the FIFO never overflows. A write into a full FIFO is a design error; flag it with an assertion.
- Stream rules:
  - src_valid = FIFO not empty; src_data = FIFO head (first-word-fall-through).
  - A pop occurs when src_valid && src_ready. Simultaneous push and pop leaves the count unchanged.
  - src_data must hold stable while src_valid && !src_ready.
- Throughput: with src_ready held high, one word per cycle sustained. First src_valid appears READ_LATENCY+1 cycles after start is sampled.
- start and abort in the same cycle while IDLE: start wins. While busy, start is ignored and abort acts.
- Asserting reset_n low mid-transfer clears everything asynchronously. No done or aborted pulse is produced.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ISSUE, DRAIN, FLUSH),
  - the default widths (ADDR_W = 16, DATA_W = 32),
  - the memory depth constant 40960 words.
- One sub-module, sample_fifo: synchronous first-word-fall-through FIFO, parameterised by width and depth, with a count output and a clear input.
- The FSM, address counter and credit logic stay in the top module.

Test Plan:
1. base_addr=0x0010, length=8, src_ready=1, memory word i = 0xA5000000+i -> addresses 0x0010..0x0017 issued on consecutive cycles; stream 0xA5000010..0xA5000017 in order; done pulses once; busy low afterwards.
2. src_ready held 0 after start, length=10, FIFO_DEPTH=4 -> exactly 4 reads issued then avm_read stays low; releasing src_ready resumes reads; all 10 words delivered in order with no loss or duplication.
3. base_addr=0xFFFE, length=4 -> issued addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
4. length=0 -> no avm_read ever; done pulses one cycle after start; busy stays 0.
5. abort asserted after 3 words accepted, length=20, with reads in flight -> avm_read drops the same cycle; src_valid drops once the FIFO is cleared; aborted pulses after in-flight returns are discarded; no done pulse; a new start then runs cleanly.
6. reset_n pulsed low mid-transfer, and random src_ready at 50% over length=100 -> after reset all outputs are at reset values; the random-ready run delivers the 100 words in order with src_data stable while stalled.

Source files
------------

// File: rtl/avalon_sample_reader_pkg.sv
// Shared definitions for the Avalon-MM sample reader.
// Holds the controller state encoding, the default bus widths, the size of
// the on-chip sample memory and a small population-count helper used to turn
// the read-tag shift register into an in-flight read count.
package avalon_sample_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int MEM_DEPTH_WORDS = 40960;

  // Counts set bits of a read-tag vector (read latency is at most 3).
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/avalon_sample_reader_chk.sv
// Property checker for the sample reader.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   fifo_push     write strobe into the output FIFO
//   fifo_full     FIFO full flag
module avalon_sample_reader_chk (
  input logic clk,
  input logic reset_n,
  input logic fifo_push,
  input logic fifo_full
);

  // Credit accounting must keep every FIFO write within capacity.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full));

endmodule

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous flush; wins over push/pop in the same cycle
//   push/push_data write one entry (caller guarantees space)
//   pop            remove the head entry (ignored while empty)
//   head           current head entry, valid whenever !empty
//   empty/full     occupancy flags
//   count          number of stored entries (0..DEPTH)
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop_s = pop && (count_q != '0);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/avalon_sample_reader.sv
// Avalon-MM read master streaming a block of sample words.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          one-cycle control pulses
//   base_addr, length     transfer descriptor latched on an accepted start
//   busy, done, aborted   transfer status (done/aborted are one-cycle pulses)
//   avm_*                 Avalon-MM read master to the fixed-latency memory
//   src_data/valid/ready  first-word-fall-through output stream
// Reads are only issued while FIFO occupancy plus outstanding reads leaves a
// free slot, so every returning word is guaranteed a place in the FIFO.
module avalon_sample_reader
  import avalon_sample_reader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic [1:0]       inflight_s;
  logic             credit_s;
  logic             issue_s;
  logic             abort_take_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_clear_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             drain_done_s;

  // Credit, issue and FIFO control derived from the current state.
  always_comb begin
    inflight_s   = popcount3(3'(tag_q));
    credit_s     = (SUM_W'(fifo_count_s) + SUM_W'(inflight_s)) < SUM_W'(FIFO_DEPTH);
    abort_take_s = abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    // abort gates the request combinationally so no read escapes in its cycle
    issue_s      = (state_q == ST_ISSUE) && credit_s && !abort;
    // returns still arriving after an abort are dropped, not stored
    fifo_push_s  = tag_q[READ_LATENCY-1] && (state_q != ST_FLUSH);
    fifo_pop_s   = !fifo_empty_s && src_ready;
    fifo_clear_s = abort_take_s || (state_q == ST_FLUSH);
    // finished once nothing is outstanding and the last word leaves this cycle
    drain_done_s = (inflight_s == 2'd0) &&
                   ((fifo_count_s == CNT_W'(0)) ||
                    ((fifo_count_s == CNT_W'(1)) && fifo_pop_s));
    tag_d        = tag_q << 1;
    tag_d[0]     = issue_s;
  end

  // Controller next-state, address counter and status pulses.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = base_addr;
            remaining_d = length;
            state_d     = ST_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (issue_s) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (drain_done_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (inflight_s == 2'd0) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (fifo_clear_s),
    .push      (fifo_push_s),
    .push_data (avm_readdata),
    .pop       (fifo_pop_s),
    .head      (src_data),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  avalon_sample_reader_chk u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .fifo_push (fifo_push_s),
    .fifo_full (fifo_full_s)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign avm_read       = issue_s;
  assign avm_chipselect = issue_s;
  assign avm_address    = addr_q;
  assign avm_byteenable = '1;
  assign src_valid      = !fifo_empty_s;

endmodule

// File: tb/tb_avalon_sample_reader.sv
module tb_avalon_sample_reader;

  localparam int RL    = 1;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;

  avalon_sample_reader #(
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready)
  );

  // Reference memory and scoreboard state.
  logic [31:0] mem [65536];
  logic [31:0] rd_pipe [RL];
  logic [31:0] exp_data_q[$];
  logic [15:0] exp_addr_q[$];
  int          issue_cycles[$];
  int checks = 0, errors = 0;
  int cycle = 0, read_count = 0, accepted = 0, done_count = 0, aborted_count = 0;
  bit rand_ready = 0, ready_val = 1;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Fixed-latency memory slave.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[avm_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign avm_readdata = rd_pipe[RL-1];

  // Downstream ready driver.
  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      src_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares the stream and the read requests against the queues.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(src_valid), 32'd1);
        check("stall_data", src_data, prev_data);
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (src_valid && src_ready) begin
        accepted++;
        if (exp_data_q.size() == 0) check("unexpected_word", src_data, 32'hxxxxxxxx);
        else check("stream_data", src_data, exp_data_q.pop_front());
      end
      check("chipselect_eq_read", 32'(avm_chipselect), 32'(avm_read));
      if (avm_read) begin
        read_count++;
        issue_cycles.push_back(cycle);
        if (exp_addr_q.size() == 0) check("unexpected_read", 32'(avm_address), 32'hxxxxxxxx);
        else check("avm_address", 32'(avm_address), 32'(exp_addr_q.pop_front()));
      end
      done_count    += int'(done);
      aborted_count += int'(aborted);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queues the expected reads/words, then pulses start (optionally with abort).
  task automatic start_xfer(input logic [15:0] b, input logic [15:0] l, input bit with_abort);
    for (int i = 0; i < int'(l); i++) begin
      exp_addr_q.push_back(b + 16'(i));
      exp_data_q.push_back(mem[b + 16'(i)]);
    end
    base_addr = b;
    length    = l;
    start     = 1'b1;
    abort     = with_abort;
    step(1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_pulse(input bit ab, input int budget, input string name);
    int  c0   = ab ? aborted_count : done_count;
    bit  seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if ((ab ? aborted_count : done_count) != c0) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    check({tag, "_chipselect"}, 32'(avm_chipselect), 32'd0);
    check({tag, "_src_valid"}, 32'(src_valid), 32'd0);
    check({tag, "_avm_address"}, 32'(avm_address), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_words_left"}, 32'(exp_data_q.size()), 32'd0);
    check({tag, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0, dc0, ac0, acc0;
    logic [15:0] b, l;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 32'hA500_0000 + 32'(a);
    #23;
    check_reset("reset");
    check("reset_byteenable", 32'(avm_byteenable), 32'h0000000F);
    @(posedge clk); #1; reset_n = 1'b1;
    step(2);

    // 1: basic block, ready high, latency and back-to-back issue.
    issue_cycles.delete();
    dc0 = done_count;
    start_xfer(16'h0010, 16'd8, 1'b0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    step(1);
    check("t1_valid_early", 32'(src_valid), 32'd0);
    step(1);
    check("t1_first_valid", 32'(src_valid), 32'd1);
    wait_pulse(1'b0, 50, "t1_done");
    check_drained("t1");
    check("t1_issue_count", 32'(issue_cycles.size()), 32'd8);
    if (issue_cycles.size() == 8) check("t1_consecutive", 32'(issue_cycles[7] - issue_cycles[0]), 32'd7);
    step(3);
    check("t1_done_once", 32'(done_count - dc0), 32'd1);

    // 2: downstream stalled, credit limits reads to FIFO depth.
    ready_val = 1'b0;
    step(2);
    rc0 = read_count;
    start_xfer(16'h0100, 16'd10, 1'b0);
    step(20);
    check("t2_reads_stalled", 32'(read_count - rc0), 32'(DEPTH));
    check("t2_read_low", 32'(avm_read), 32'd0);
    ready_val = 1'b1;
    wait_pulse(1'b0, 100, "t2_done");
    check_drained("t2");
    check("t2_reads_total", 32'(read_count - rc0), 32'd10);

    // 3: address wrap.
    start_xfer(16'hFFFE, 16'd4, 1'b0);
    wait_pulse(1'b0, 50, "t3_done");
    check_drained("t3");

    // 4: zero length.
    rc0 = read_count; dc0 = done_count;
    start_xfer(16'h1234, 16'd0, 1'b0);
    check("t4_done_next", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    step(1);
    check("t4_done_single", 32'(done), 32'd0);
    step(3);
    check("t4_no_reads", 32'(read_count - rc0), 32'd0);
    check("t4_done_count", 32'(done_count - dc0), 32'd1);

    // abort in IDLE is ignored
    ac0 = aborted_count;
    abort = 1'b1; step(1); abort = 1'b0; step(2);
    check("idle_abort_ignored", 32'(aborted_count - ac0), 32'd0);

    // 5: abort with reads in flight.
    dc0 = done_count; ac0 = aborted_count; acc0 = accepted;
    start_xfer(16'h0300, 16'd20, 1'b0);
    for (int i = 0; i < 60 && (accepted - acc0) < 3; i++) step(1);
    check("t5_three_accepted", 32'(accepted - acc0 >= 3), 32'd1);
    check("t5_read_before", 32'(avm_read), 32'd1);
    abort = 1'b1;
    #1;
    check("t5_read_drops", 32'(avm_read), 32'd0);
    rc0 = read_count;
    step(1);
    abort = 1'b0;
    check("t5_fifo_cleared", 32'(src_valid), 32'd0);
    check("t5_busy_flush", 32'(busy), 32'd1);
    wait_pulse(1'b1, 20, "t5_aborted");
    check("t5_no_reads", 32'(read_count - rc0), 32'd0);
    check("t5_no_done", 32'(done_count - dc0), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_valid_low", 32'(src_valid), 32'd0);
    check("t5_aborted_once", 32'(aborted_count - ac0), 32'd1);
    exp_data_q.delete();
    exp_addr_q.delete();
    // restart; start and abort together in IDLE, start wins
    start_xfer(16'h0400, 16'd6, 1'b1);
    wait_pulse(1'b0, 50, "t5_restart_done");
    check_drained("t5_restart");

    // 6: reset mid-transfer.
    dc0 = done_count; ac0 = aborted_count;
    start_xfer(16'h0500, 16'd30, 1'b0);
    step(8);
    reset_n = 1'b0;
    #1;
    check_reset("midreset");
    exp_data_q.delete();
    exp_addr_q.delete();
    step(2);
    reset_n = 1'b1;
    step(2);
    check("midreset_no_done", 32'(done_count - dc0), 32'd0);
    check("midreset_no_aborted", 32'(aborted_count - ac0), 32'd0);

    // 6b: random ready over 100 random words; stray start while busy.
    b = 16'($urandom);
    for (int i = 0; i < 100; i++) mem[b + 16'(i)] = $urandom;
    rand_ready = 1'b1;
    start_xfer(b, 16'd100, 1'b0);
    step(10);
    base_addr = ~b; length = 16'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    check("t6_busy_ignores_start", 32'(busy), 32'd1);
    wait_pulse(1'b0, 1000, "t6_done");
    check_drained("t6");

    // further random transfers
    for (int t = 0; t < 3; t++) begin
      b = 16'($urandom);
      l = 16'($urandom_range(1, 40));
      for (int i = 0; i < int'(l); i++) mem[b + 16'(i)] = $urandom;
      start_xfer(b, l, 1'b0);
      wait_pulse(1'b0, 500, "rand_done");
      check_drained("rand");
    end
    rand_ready = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
